// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB slave responder.
package sccb_pkg;

  localparam int         BYTE_W        = 8;
  localparam logic [6:0] SCCB_DEF_ADDR = 7'h21;
  localparam logic       SCCB_WR       = 1'b0;
  localparam logic       SCCB_RD       = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchroniser, glitch filter and edge pulses for one open-drain bus line.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic filt,
  output logic rise,
  output logic fall
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sample;

  always_comb begin
    sync_d = SYNC_STAGES'({sync_q, din});
    sample = sync_q[SYNC_STAGES-1];
    filt_d = filt_q;
    cnt_d  = '0;
    // The filtered level only follows after FILTER_LEN consecutive differing samples.
    if (sample != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) filt_d = sample;
      else                                 cnt_d  = cnt_q + 1'b1;
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // Bus idles high, so reset to 1 to avoid a spurious edge on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign filt = filt_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/sccb_slave_responder.sv
// SCCB/I2C register slave: START/ADDR/REG/DATA/STOP decode, ACKs, byte register port.
// Define SCCB_READ_EN to serve R/W=1 transfers from reg_rdata; otherwise reads are ignored.
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = SCCB_DEF_ADDR,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILTER_LEN  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [BYTE_W-1:0] reg_addr,
  output logic [BYTE_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [BYTE_W-1:0] reg_rdata,
  output logic              busy
);
  logic fs, fs_rise, fs_fall, fd, fd_rise, fd_fall;
  logic start_det, stop_det, addr_ok;
  logic [BYTE_W-1:0] byte_in;

  sccb_state_e       state_q, state_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic              sda_oe_q, sda_oe_d;
  logic [BYTE_W-1:0] reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              busy_q, busy_d;

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_sync (
    .clk(clk), .rst(rst), .din(scl), .filt(fs), .rise(fs_rise), .fall(fs_fall)
  );

  sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_sync (
    .clk(clk), .rst(rst), .din(sda_i), .filt(fd), .rise(fd_rise), .fall(fd_fall)
  );

  assign start_det = fd_fall & fs;
  assign stop_det  = fd_rise & fs;
  assign byte_in   = {shift_q, fd};

`ifdef SCCB_READ_EN
  logic [6:0] rd_shift_q, rd_shift_d;
  logic       rw_q, rw_d;
  assign addr_ok = (byte_in[7:1] == SLAVE_ADDR);
`else
  logic rdata_unused;
  assign rdata_unused = ^reg_rdata;
  assign addr_ok      = (byte_in[7:1] == SLAVE_ADDR) && (byte_in[0] == SCCB_WR);
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    busy_d      = busy_q;
`ifdef SCCB_READ_EN
    rd_shift_d  = rd_shift_q;
    rw_d        = rw_q;
`endif
    if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_DATA: begin
          if (fs_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              if (state_q == ST_ADDR) begin
                state_d = addr_ok ? ST_ADDR_ACK : ST_IGNORE;
                busy_d  = busy_q | addr_ok;
`ifdef SCCB_READ_EN
                rw_d    = byte_in[0];
`endif
              end else if (state_q == ST_REG) begin
                reg_addr_d = byte_in;
                state_d    = ST_REG_ACK;
              end else begin
                reg_wdata_d = byte_in;
                reg_we_d    = 1'b1;
                state_d     = ST_DATA_ACK;
              end
            end
          end
        end
        // First SCL fall opens the ACK slot, the second one closes it.
        ST_ADDR_ACK, ST_REG_ACK, ST_DATA_ACK: begin
          if (fs_fall) begin
            sda_oe_d = ~sda_oe_q;
            if (sda_oe_q) begin
              state_d = (state_q == ST_ADDR_ACK) ? ST_REG : ST_DATA;
              if (state_q == ST_DATA_ACK) reg_addr_d = reg_addr_q + 8'd1;
`ifdef SCCB_READ_EN
              if (state_q == ST_ADDR_ACK && rw_q == SCCB_RD) begin
                state_d    = ST_RD_DATA;
                sda_oe_d   = ~reg_rdata[7];
                rd_shift_d = reg_rdata[6:0];
              end
`endif
            end
          end
        end
`ifdef SCCB_READ_EN
        ST_RD_DATA: begin
          if (fs_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (fs_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = ST_RD_ACK;
            end else begin
              sda_oe_d   = ~rd_shift_q[6];
              rd_shift_d = {rd_shift_q[5:0], 1'b0};
            end
          end
        end
        // bit_cnt=1 marks a master ACK seen; the following fall reloads from the new pointer.
        ST_RD_ACK: begin
          if (fs_rise) begin
            if (fd) begin
              state_d = ST_IGNORE;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = 4'd1;
            end
          end else if (fs_fall && bit_cnt_q == 4'd1) begin
            state_d    = ST_RD_DATA;
            bit_cnt_d  = '0;
            sda_oe_d   = ~reg_rdata[7];
            rd_shift_d = reg_rdata[6:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SCCB_READ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_shift_q <= '0;
      rw_q       <= SCCB_WR;
    end else begin
      rd_shift_q <= rd_shift_d;
      rw_q       <= rw_d;
    end
  end
`endif

  assign sda_oe    = sda_oe_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Bench for sccb_slave_responder: bit-banged SCCB master, write-log monitor, table and random checks.
module tb_sccb_slave_responder;
  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst, scl, m_sda, sda_i, sda_oe, reg_we, busy;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic [7:0] rmem [256];

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int  oe_cnt = 0, busy_cnt = 0;
  int  we_base, oe_base, busy_base;
  int  total = 0, bad = 0;

  typedef struct {
    logic [7:0]  dev, rg;
    logic [23:0] dat;
    int          nd, exp_acks, exp_we;
    logic [7:0]  exp_la, exp_ld, exp_ptr;
    int          exp_busy;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;
  assign sda_i     = m_sda & ~sda_oe;
  assign reg_rdata = rmem[reg_addr];

  sccb_slave_responder dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always @(negedge clk) begin
    if (reg_we) got_q.push_back('{reg_addr, reg_wdata});
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", nm, got, exp);
    end
  endtask

  task automatic start_c();
    if (scl == 1'b0) begin
      m_sda = 1'b1; wclk(Q);
      scl = 1'b1;   wclk(Q);
    end
    m_sda = 1'b0; wclk(Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic stop_c();
    m_sda = 1'b0; wclk(Q);
    scl = 1'b1;   wclk(Q);
    m_sda = 1'b1; wclk(Q);
    wclk(Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;  wclk(Q);
    scl = 1'b1; wclk(2 * Q);
    scl = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output int ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_sda = 1'b1; wclk(Q);
    scl = 1'b1;   wclk(Q);
    ack = (sda_i == 1'b0) ? 1 : 0;
    wclk(Q);
    scl = 1'b0;   wclk(Q);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(Q);
      scl = 1'b1; wclk(Q);
      b[i] = sda_i;
      wclk(Q);
      scl = 1'b0;
    end
    wclk(Q);
    m_sda = mack; wclk(Q);
    scl = 1'b1;   wclk(2 * Q);
    scl = 1'b0;   wclk(Q);
    m_sda = 1'b1;
  endtask

  task automatic snap();
    we_base = got_q.size(); oe_base = oe_cnt; busy_base = busy_cnt;
  endtask

  task automatic xfer(input logic [7:0] dev, input logic [7:0] rg, input logic [23:0] dat,
                      input int nd, output int acks);
    int a;
    acks = 0;
    snap();
    start_c();
    write_byte(dev, a); acks += a;
    write_byte(rg, a);  acks += a;
    for (int k = 0; k < nd; k++) begin
      write_byte(dat[23-8*k -: 8], a); acks += a;
    end
    stop_c();
  endtask

  initial begin
    int          acks, a, nd;
    logic [7:0]  dev, rg, mp, rb, b42;
    logic [23:0] dat;
    wr_t         w;

    vt[0] = '{8'h42, 8'h12, 24'h800000, 1, 3, 1, 8'h12, 8'h80, 8'h13, 1};
    vt[1] = '{8'h60, 8'h12, 24'h345600, 2, 0, 0, 8'h00, 8'h00, 8'h13, 0};
    vt[2] = '{8'h42, 8'hFF, 24'hAA5500, 2, 4, 2, 8'h00, 8'h55, 8'h01, 1};
    vt[3] = '{8'h42, 8'h00, 24'h000000, 0, 2, 0, 8'h00, 8'h00, 8'h00, 1};
    vt[4] = '{8'h44, 8'h77, 24'h112233, 3, 0, 0, 8'h00, 8'h00, 8'h00, 0};
    vt[5] = '{8'h42, 8'h50, 24'h010203, 3, 5, 3, 8'h52, 8'h03, 8'h53, 1};
    for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
    rmem[8'h0A] = 8'h76;
    rmem[8'h0B] = 8'h3C;
    b42 = 8'h42;

    rst = 1'b1; scl = 1'b1; m_sda = 1'b1;
    wclk(3);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_reg_addr", reg_addr, 0);
    chk("rst_reg_wdata", reg_wdata, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    wclk(10);

    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].dev, vt[i].rg, vt[i].dat, vt[i].nd, acks);
      chk($sformatf("v%0d_acks", i), acks, vt[i].exp_acks);
      chk($sformatf("v%0d_we_cnt", i), got_q.size() - we_base, vt[i].exp_we);
      if (vt[i].exp_we > 0 && got_q.size() > 0) begin
        w = got_q[got_q.size()-1];
        chk($sformatf("v%0d_last_addr", i), w.a, vt[i].exp_la);
        chk($sformatf("v%0d_last_data", i), w.d, vt[i].exp_ld);
      end
      chk($sformatf("v%0d_ptr", i), reg_addr, vt[i].exp_ptr);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_busy_seen", i), (busy_cnt > busy_base) ? 1 : 0, vt[i].exp_busy);
      chk($sformatf("v%0d_oe_seen", i), (oe_cnt > oe_base) ? 1 : 0, (vt[i].exp_acks > 0) ? 1 : 0);
    end

    // STOP after four data bits: no write, pointer kept
    snap();
    start_c();
    write_byte(8'h42, a); write_byte(8'h05, a);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    stop_c();
    chk("partial_stop_we", got_q.size() - we_base, 0);
    chk("partial_stop_ptr", reg_addr, 8'h05);
    chk("partial_stop_busy", busy, 0);

    // Repeated START in the middle of a data byte
    snap();
    start_c();
    write_byte(8'h42, a); write_byte(8'h07, a);
    write_bit(1'b1); write_bit(1'b1); write_bit(1'b0);
    start_c();
    acks = 0;
    write_byte(8'h42, a); acks += a;
    write_byte(8'h09, a); acks += a;
    write_byte(8'h3C, a); acks += a;
    stop_c();
    chk("rstart_acks", acks, 3);
    chk("rstart_we_cnt", got_q.size() - we_base, 1);
    if (got_q.size() > we_base) begin
      w = got_q[we_base];
      chk("rstart_addr", w.a, 8'h09);
      chk("rstart_data", w.d, 8'h3C);
    end
    chk("rstart_ptr", reg_addr, 8'h0A);

    // Two-clock SCL glitch right after START must not count as a bit
    snap();
    start_c();
    m_sda = 1'b0; wclk(Q);
    scl = 1'b1; wclk(2);
    scl = 1'b0; wclk(Q);
    acks = 0;
    write_byte(8'h42, a); acks += a;
    write_byte(8'h20, a); acks += a;
    write_byte(8'h11, a); acks += a;
    stop_c();
    chk("glitch_acks", acks, 3);
    chk("glitch_we_cnt", got_q.size() - we_base, 1);
    if (got_q.size() > we_base) begin
      w = got_q[we_base];
      chk("glitch_addr", w.a, 8'h20);
      chk("glitch_data", w.d, 8'h11);
    end

`ifdef SCCB_READ_EN
    xfer(8'h42, 8'h0A, 24'h0, 0, acks);
    chk("rd_setptr_acks", acks, 2);
    start_c();
    write_byte(8'h43, a);
    chk("rd_addr_ack", a, 1);
    read_byte(1'b0, rb);
    chk("rd_byte0", rb, 8'h76);
    chk("rd_ptr_inc", reg_addr, 8'h0B);
    read_byte(1'b1, rb);
    chk("rd_byte1", rb, 8'h3C);
    chk("rd_nack_release", sda_oe, 0);
    stop_c();
    chk("rd_ptr_end", reg_addr, 8'h0B);
    chk("rd_busy_end", busy, 0);
`else
    xfer(8'h43, 8'h55, 24'h660000, 1, acks);
    chk("rd_off_acks", acks, 0);
    chk("rd_off_oe_seen", (oe_cnt > oe_base) ? 1 : 0, 0);
    chk("rd_off_busy_seen", (busy_cnt > busy_base) ? 1 : 0, 0);
    chk("rd_off_we_cnt", got_q.size() - we_base, 0);
`endif

    // Reset while the slave holds the address ACK
    start_c();
    for (int k = 7; k >= 0; k--) write_bit(b42[k]);
    m_sda = 1'b1; wclk(Q);
    chk("ack_before_rst", sda_oe, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sda_oe", sda_oe, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_reg_addr", reg_addr, 0);
    wclk(2);
    rst = 1'b0;
    scl = 1'b1; wclk(Q);
    scl = 1'b0; wclk(Q);
    stop_c();
    xfer(8'h42, 8'h30, 24'h990000, 1, acks);
    chk("post_rst_acks", acks, 3);
    chk("post_rst_we_cnt", got_q.size() - we_base, 1);
    chk("post_rst_ptr", reg_addr, 8'h31);

    // Random write/mismatch traffic against a transaction-level pointer model
    mp = 8'h31;
    for (int t = 0; t < 12; t++) begin
      if (t == 0 || $urandom_range(0, 1) == 1) dev = 8'h42;
      else begin
        dev = 8'($urandom_range(0, 255));
        while (dev == 8'h42 || dev == 8'h43) dev = 8'($urandom_range(0, 255));
      end
      rg  = 8'($urandom);
      dat = 24'($urandom);
      nd  = $urandom_range(0, 3);
      exp_q.delete();
      if (dev == 8'h42) begin
        mp = rg;
        for (int k = 0; k < nd; k++) begin
          exp_q.push_back('{mp, dat[23-8*k -: 8]});
          mp = mp + 8'd1;
        end
      end
      xfer(dev, rg, dat, nd, acks);
      chk($sformatf("rnd%0d_acks", t), acks, (dev == 8'h42) ? 2 + nd : 0);
      chk($sformatf("rnd%0d_we_cnt", t), got_q.size() - we_base, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++) begin
        if (we_base + k < got_q.size())
          chk($sformatf("rnd%0d_wr%0d", t, k), got_q[we_base + k], exp_q[k]);
      end
      chk($sformatf("rnd%0d_ptr", t), reg_addr, mp);
      chk($sformatf("rnd%0d_busy_end", t), busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
